// File: rtl/reg_file_cc.sv
// LC-3 register file (R0-R7) with SR1/SR2 operand selection, NZP condition codes
// and the registered branch-enable flag.
module reg_file_cc (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] IR,
  input  logic [15:0] BUS,
  input  logic        LD_REG,
  input  logic        LD_CC,
  input  logic        LD_BEN,
  input  logic        DRMUX,
  input  logic        SR1MUX,
  output logic [15:0] SR1_OUT,
  output logic [15:0] SR2_MUX_OUT,
  output logic [2:0]  NZP,
  output logic        BEN
);

  logic [15:0] regs [8];
  logic [2:0]  dr_sel;
  logic [2:0]  sr1_sel;
  logic [2:0]  nzp_next;
  logic        ben_next;

  assign dr_sel  = DRMUX ? 3'd7 : IR[11:9];
  assign sr1_sel = SR1MUX ? IR[8:6] : IR[11:9];

  // Reads come straight from register state, so a write is visible only after its edge.
  assign SR1_OUT     = regs[sr1_sel];
  assign SR2_MUX_OUT = IR[5] ? {{11{IR[4]}}, IR[4:0]} : regs[IR[2:0]];

  always_comb begin
    nzp_next = 3'b001;
    if (BUS == 16'h0000)
      nzp_next = 3'b010;
    else if (BUS[15])
      nzp_next = 3'b100;
  end

  // BEN is evaluated from the NZP currently held, never from this edge's update.
  assign ben_next = (IR[11] & NZP[2]) | (IR[10] & NZP[1]) | (IR[9] & NZP[0]);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++)
        regs[i] <= 16'h0000;
    end else if (LD_REG) begin
      regs[dr_sel] <= BUS;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      NZP <= 3'b010;
      BEN <= 1'b0;
    end else begin
      if (LD_CC)
        NZP <= nzp_next;
      if (LD_BEN)
        BEN <= ben_next;
    end
  end

endmodule

// File: tb/tb_reg_file_cc.sv
// Directed self-checking bench for reg_file_cc: reset, write/read, bypass,
// immediates, condition codes and BEN ordering.
module tb_reg_file_cc;

  logic        Clk;
  logic        Reset;
  logic [15:0] IR;
  logic [15:0] BUS;
  logic        LD_REG;
  logic        LD_CC;
  logic        LD_BEN;
  logic        DRMUX;
  logic        SR1MUX;
  logic [15:0] SR1_OUT;
  logic [15:0] SR2_MUX_OUT;
  logic [2:0]  NZP;
  logic        BEN;

  int checks = 0;
  int errors = 0;

  reg_file_cc dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .IR          (IR),
    .BUS         (BUS),
    .LD_REG      (LD_REG),
    .LD_CC       (LD_CC),
    .LD_BEN      (LD_BEN),
    .DRMUX       (DRMUX),
    .SR1MUX      (SR1MUX),
    .SR1_OUT     (SR1_OUT),
    .SR2_MUX_OUT (SR2_MUX_OUT),
    .NZP         (NZP),
    .BEN         (BEN)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset  = 1'b1;
    IR     = 16'h0000;
    BUS    = 16'h0000;
    LD_REG = 1'b0;
    LD_CC  = 1'b0;
    LD_BEN = 1'b0;
    DRMUX  = 1'b0;
    SR1MUX = 1'b0;
    #2;
    check("reset_sr1", SR1_OUT, 16'h0000);
    check("reset_sr2", SR2_MUX_OUT, 16'h0000);
    check("reset_nzp", {13'b0, NZP}, 16'h0002);
    check("reset_ben", {15'b0, BEN}, 16'h0000);

    // loads are ignored while Reset is high
    LD_REG = 1'b1;
    LD_CC  = 1'b1;
    BUS    = 16'h8123;
    tick();
    check("load_in_reset_r0", SR1_OUT, 16'h0000);
    check("load_in_reset_nzp", {13'b0, NZP}, 16'h0002);
    LD_REG = 1'b0;
    LD_CC  = 1'b0;
    Reset  = 1'b0;

    for (int i = 0; i < 8; i++) begin
      IR     = {4'b0000, 3'(i), 9'b0};
      BUS    = 16'h1110 + 16'(i);
      LD_REG = 1'b1;
      tick();
    end
    LD_REG = 1'b0;

    SR1MUX = 1'b1;
    for (int i = 0; i < 8; i++) begin
      IR = {7'b0, 3'(i), 3'b000, 3'(i)};
      #1;
      check($sformatf("read_sr1_r%0d", i), SR1_OUT, 16'h1110 + 16'(i));
      check($sformatf("read_sr2_r%0d", i), SR2_MUX_OUT, 16'h1110 + 16'(i));
    end

    IR     = {4'b0000, 3'd3, 9'b0};
    DRMUX  = 1'b1;
    BUS    = 16'hBEEF;
    LD_REG = 1'b1;
    tick();
    LD_REG = 1'b0;
    DRMUX  = 1'b0;
    IR     = {7'b0, 3'd7, 3'b000, 3'd3};
    #1;
    check("drmux_r7", SR1_OUT, 16'hBEEF);
    check("drmux_r3_untouched", SR2_MUX_OUT, 16'h1113);

    SR1MUX = 1'b0;
    IR     = {4'b0000, 3'd3, 9'b0};
    BUS    = 16'h00AA;
    LD_REG = 1'b1;
    #1;
    check("no_bypass_before", SR1_OUT, 16'h1113);
    tick();
    check("no_bypass_after", SR1_OUT, 16'h00AA);
    LD_REG = 1'b0;

    IR = 16'h002F;
    #1;
    check("imm_pos", SR2_MUX_OUT, 16'h000F);
    IR = 16'h0030;
    #1;
    check("imm_neg", SR2_MUX_OUT, 16'hFFF0);

    LD_CC = 1'b1;
    BUS   = 16'h8000;
    tick();
    check("cc_neg", {13'b0, NZP}, 16'h0004);
    BUS = 16'h0000;
    tick();
    check("cc_zero", {13'b0, NZP}, 16'h0002);
    BUS = 16'h7FFF;
    tick();
    check("cc_pos", {13'b0, NZP}, 16'h0001);
    LD_CC = 1'b0;
    BUS   = 16'h8000;
    tick();
    check("cc_hold", {13'b0, NZP}, 16'h0001);
    BUS = 16'hxxxx;
    tick();
    check("cc_hold_x", {13'b0, NZP}, 16'h0001);
    IR = {4'b0000, 3'd3, 9'b0};
    #1;
    check("reg_hold_x", SR1_OUT, 16'h00AA);

    // LD_REG and LD_CC together
    IR     = {4'b0000, 3'd2, 9'b0};
    BUS    = 16'h0000;
    LD_REG = 1'b1;
    LD_CC  = 1'b1;
    tick();
    LD_REG = 1'b0;
    LD_CC  = 1'b0;
    check("reg_cc_both_reg", SR1_OUT, 16'h0000);
    check("reg_cc_both_nzp", {13'b0, NZP}, 16'h0002);

    IR     = 16'h0400;
    BUS    = 16'h0005;
    LD_CC  = 1'b1;
    LD_BEN = 1'b1;
    tick();
    check("ben_old_z", {15'b0, BEN}, 16'h0001);
    check("ben_new_nzp", {13'b0, NZP}, 16'h0001);
    LD_CC = 1'b0;
    tick();
    check("ben_only_z_miss", {15'b0, BEN}, 16'h0000);
    IR = 16'h0200;
    tick();
    check("ben_p_hit", {15'b0, BEN}, 16'h0001);
    LD_BEN = 1'b0;
    IR     = 16'h0000;
    tick();
    check("ben_hold", {15'b0, BEN}, 16'h0001);

    // asynchronous reset in the middle of a cycle
    SR1MUX = 1'b1;
    IR     = {7'b0, 3'd7, 6'b0};
    @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    check("async_reset_r7", SR1_OUT, 16'h0000);
    check("async_reset_nzp", {13'b0, NZP}, 16'h0002);
    check("async_reset_ben", {15'b0, BEN}, 16'h0000);
    #3;
    Reset  = 1'b0;
    DRMUX  = 1'b1;
    BUS    = 16'h1234;
    LD_REG = 1'b1;
    tick();
    LD_REG = 1'b0;
    check("first_load_after_reset", SR1_OUT, 16'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_cc.md
# reg_file_cc

Register-file and condition-code stage of the simplified LC-3 datapath. It holds the eight 16-bit general-purpose registers R0–R7 and produces the two ALU operands: SR1_OUT, and SR2_MUX_OUT (register or sign-extended imm5). On the write side it captures results from the shared bus into a destination register, updates the NZP condition codes, and registers the branch-enable (BEN) flag used by the control FSM.

## Interface
Parameters:
- none (data width fixed at 16, register count fixed at 8)

Ports:
- Clk  input  1  system clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-high; clears all state immediately
- IR  input  16  current instruction register contents
- BUS  input  16  shared datapath bus; write-back data and CC source
- LD_REG  input  1  write BUS into the selected destination register this edge
- LD_CC  input  1  update NZP from BUS this edge
- LD_BEN  input  1  update BEN this edge
- DRMUX  input  1  destination select: 0 = IR[11:9], 1 = R7
- SR1MUX  input  1  SR1 select: 0 = IR[11:9], 1 = IR[8:6]
- SR1_OUT  output  16  contents of the selected SR1 register
- SR2_MUX_OUT  output  16  IR[5]=1: sext(IR[4:0]); IR[5]=0: contents of register IR[2:0]
- NZP  output  3  condition codes {N,Z,P}
- BEN  output  1  registered branch enable

## Operation
- Storage: 8 × 16-bit registers. Reset value: all 16'h0000.
- Read ports are combinational (asynchronous read) from current register state. No write-to-read bypass: a register written on edge k reads the new value only after edge k.
- SR2 path: IR[5]=1 selects {{11{IR[4]}}, IR[4:0]}, e.g. IR[4:0]=5'b10000 gives 16'hFFF0; IR[5]=0 selects register IR[2:0].
- Write: on a rising edge with LD_REG=1, BUS is stored into R[DRMUX ? 7 : IR[11:9]]. With LD_REG=0, all registers hold.
- Condition codes: on a rising edge with LD_CC=1, NZP is loaded as follows:
  - BUS==0 gives 3'b010.
  - BUS[15]=1 gives 3'b100.
  - Otherwise NZP is 3'b001.
  - NZP is always one-hot after any load. Reset value: 3'b010.
- Branch enable: on a rising edge with LD_BEN=1, BEN is loaded with (IR[11]&N) | (IR[10]&Z) | (IR[9]&P), using the NZP register value held before that edge. Reset value: 0.
- Simultaneous LD_CC and LD_BEN on the same edge: BEN uses the old NZP, and NZP takes the new value.
- LD_REG and LD_CC on the same edge are independent, and both take effect.
- X/unknown on IR or BUS with the corresponding load enables low must not disturb stored state.

## Timing
- Operand latency is 0 cycles: SR1_OUT and SR2_MUX_OUT follow IR and register state combinationally within the same cycle, feeding the ALU.
- Write latency is 1 edge: data sampled from BUS at the rising edge with LD_REG=1 is visible on the read ports immediately after that edge.
- NZP and BEN change only at rising edges with their load enable high, or at Reset.
- Reset assertion, at any time including mid-instruction, immediately forces:
  - all registers to 0;
  - NZP to 3'b010;
  - BEN to 0.
- Loads are ignored while Reset is high. The first edge after deassertion with an enable high performs a normal load.

## Test plan
- Reset: assert Reset between clock edges → SR1_OUT=16'h0000, SR2_MUX_OUT=16'h0000 (IR[5]=0), NZP=3'b010, BEN=0, with no clock edge required.
- Write/read all: for i=0..7 write BUS=16'h1110+i to DR=i (IR[11:9]=i, DRMUX=0) → reading each via SR1MUX=1/IR[8:6]=i and via IR[2:0]=i returns 16'h1110+i. DRMUX=1 with BUS=16'hBEEF writes R7 regardless of IR[11:9].
- No bypass: the edge that writes BUS=16'h00AA to R3 while SR1 selects R3 → SR1_OUT shows the old value before the edge and 16'h00AA after it.
- Immediate: IR[5]=1, IR[4:0]=5'b01111 → SR2_MUX_OUT=16'h000F. IR[4:0]=5'b10000 → 16'hFFF0.
- CC: LD_CC with BUS=16'h8000 → NZP=100. BUS=16'h0000 → 010. BUS=16'h7FFF → 001. With LD_CC=0, a BUS change leaves NZP held.
- BEN ordering: NZP=010, IR[11:9]=3'b010, with LD_CC (BUS=16'h0005) and LD_BEN on the same edge → BEN=1 (old Z) and NZP=001. A following edge with LD_BEN=1 only → BEN=0.
